ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_pkg.sv | 55 +++++
 rtl/ex_mem_stage_if.sv | 52 +++++
 rtl/ex_muldiv.sv | 86 ++++++++
 rtl/ex_mem_stage.sv | 126 ++++++++++++
 tb/tb_ex_mem_stage.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX/MEM stage: ALU op encodings, multi-cycle FSM states, forwarding helper.
// The multi-cycle MUL/DIVU unit is enabled by defining MULDIV_EN.
package ex_mem_stage_pkg;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluNor   = 4'd5,
        AluSlt   = 4'd6,
        AluSltu  = 4'd7,
        AluSll   = 4'd8,
        AluSrl   = 4'd9,
        AluSra   = 4'd10,
        AluLui   = 4'd11,
        AluMul   = 4'd12,
        AluDivu  = 4'd13,
        AluRsv14 = 4'd14,
        AluRsv15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } md_state_e;

    localparam int unsigned MdSteps = 32;

    // MEM result beats WB result beats register file; $0 is never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic        mem_we,
        input logic [4:0]  mem_dst,
        input logic [31:0] mem_val,
        input logic        wb_we,
        input logic [4:0]  wb_dst,
        input logic [31:0] wb_val
    );
        logic [31:0] val;
        val = rf_val;
        if (src != 5'd0) begin
            if (mem_we && (mem_dst == src)) begin
                val = mem_val;
            end else if (wb_we && (wb_dst == src)) begin
                val = wb_val;
            end
        end
        return val;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM bundle: instruction fields in, pipeline register contents and stall out.
// master drives the instruction side, slave is the EX stage itself.
interface ex_mem_stage_if;
    import ex_mem_stage_pkg::*;

    logic [31:0] PC_EX;
    logic [31:0] regData1_EX;
    logic [31:0] regData2_EX;
    logic [31:0] signExtImm_EX;
    logic [4:0]  reg_rs_EX;
    logic [4:0]  reg_rt_EX;
    logic [4:0]  reg_rd_EX;
    logic        RegDst_EX;
    logic        reg_write_EX;
    logic        Memread_EX;
    logic        MemtoReg_EX;
    logic        MemWrite_EX;
    logic        AluSrc_EX;
    alu_op_e     AluOp_EX;

    logic        flush_EX;
    logic        wb_reg_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    logic [31:0] PC_MEM;
    logic [31:0] ALU_result_MEM;
    logic [31:0] store_data_MEM;
    logic [4:0]  reg_dst_MEM;
    logic        reg_write_MEM;
    logic        Memread_MEM;
    logic        MemtoReg_MEM;
    logic        MemWrite_MEM;
    logic        stall_EX;

    modport master (
        output PC_EX, regData1_EX, regData2_EX, signExtImm_EX, reg_rs_EX, reg_rt_EX, reg_rd_EX,
               RegDst_EX, reg_write_EX, Memread_EX, MemtoReg_EX, MemWrite_EX, AluSrc_EX,
               AluOp_EX, flush_EX, wb_reg_write, wb_reg, wb_data,
        input  PC_MEM, ALU_result_MEM, store_data_MEM, reg_dst_MEM, reg_write_MEM,
               Memread_MEM, MemtoReg_MEM, MemWrite_MEM, stall_EX
    );

    modport slave (
        input  PC_EX, regData1_EX, regData2_EX, signExtImm_EX, reg_rs_EX, reg_rt_EX, reg_rd_EX,
               RegDst_EX, reg_write_EX, Memread_EX, MemtoReg_EX, MemWrite_EX, AluSrc_EX,
               AluOp_EX, flush_EX, wb_reg_write, wb_reg, wb_data,
        output PC_MEM, ALU_result_MEM, store_data_MEM, reg_dst_MEM, reg_write_MEM,
               Memread_MEM, MemtoReg_MEM, MemWrite_MEM, stall_EX
    );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-step shift-add multiplier / restoring divider (unsigned), one step per cycle.
// Only instantiated when MULDIV_EN is defined.
module ex_muldiv
    import ex_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    md_state_e   r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic [31:0] r_x;    // multiplicand (MUL) or dividend shifting into quotient (DIVU)
    logic [31:0] r_y;    // multiplier (MUL) or divisor (DIVU)
    logic [31:0] r_acc;  // product (MUL) or partial remainder (DIVU)

    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [32:0] w_diff;

    assign w_rem_sh = {r_acc, r_x[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_y});
    assign w_diff   = w_rem_sh - {1'b0, r_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_x      <= 32'd0;
            r_y      <= 32'd0;
            r_acc    <= 32'd0;
        end else if (i_flush) begin
            r_state <= StIdle;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state  <= StBusy;
                        r_cnt    <= 5'd0;
                        r_is_div <= (i_op == AluDivu);
                        r_x      <= i_a;
                        r_y      <= i_b;
                        r_acc    <= 32'd0;
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(MdSteps - 1)) begin
                        r_state <= StDone;
                    end
                    if (r_is_div) begin
                        r_acc <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
                        r_x   <= {r_x[30:0], w_ge};
                    end else begin
                        if (r_y[0]) begin
                            r_acc <= r_acc + r_x;
                        end
                        r_x <= {r_x[30:0], 1'b0};
                        r_y <= {1'b0, r_y[31:1]};
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy   = ~i_flush & ((r_state == StBusy) | ((r_state == StIdle) & i_start));
    assign o_done   = ~i_flush & (r_state == StDone);
    assign o_result = r_is_div ? r_x : r_acc;

endmodule

// File: rtl/ex_mem_stage.sv
// EX stage with operand forwarding, single-cycle ALU and the EX/MEM pipeline register.
// Define MULDIV_EN to add the multi-cycle MUL/DIVU unit (otherwise ops 12/13 yield 0).
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave bus
);

    logic [31:0] r_pc;
    logic [31:0] r_alu;
    logic [31:0] r_sd;
    logic [4:0]  r_dst;
    logic        r_rw;
    logic        r_mr;
    logic        r_m2r;
    logic        r_mw;

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu;
    logic [31:0] w_result;
    logic [4:0]  w_shamt;
    logic        w_md_op;
    logic        w_md_done;
    logic [31:0] w_md_result;
    logic        w_stall;
    logic        w_bubble;

    assign w_fwd_a = fwd_sel(bus.reg_rs_EX, bus.regData1_EX, r_rw, r_dst, r_alu,
                             bus.wb_reg_write, bus.wb_reg, bus.wb_data);
    assign w_fwd_b = fwd_sel(bus.reg_rt_EX, bus.regData2_EX, r_rw, r_dst, r_alu,
                             bus.wb_reg_write, bus.wb_reg, bus.wb_data);
    assign w_alu_b = bus.AluSrc_EX ? bus.signExtImm_EX : w_fwd_b;
    assign w_shamt = bus.signExtImm_EX[10:6];
    assign w_md_op = (bus.AluOp_EX == AluMul) | (bus.AluOp_EX == AluDivu);

    always_comb begin
        w_alu = 32'd0;
        case (bus.AluOp_EX)
            AluAdd:  w_alu = w_fwd_a + w_alu_b;
            AluSub:  w_alu = w_fwd_a - w_alu_b;
            AluAnd:  w_alu = w_fwd_a & w_alu_b;
            AluOr:   w_alu = w_fwd_a | w_alu_b;
            AluXor:  w_alu = w_fwd_a ^ w_alu_b;
            AluNor:  w_alu = ~(w_fwd_a | w_alu_b);
            AluSlt:  w_alu = {31'd0, $signed(w_fwd_a) < $signed(w_alu_b)};
            AluSltu: w_alu = {31'd0, w_fwd_a < w_alu_b};
            AluSll:  w_alu = w_alu_b << w_shamt;
            AluSrl:  w_alu = w_alu_b >> w_shamt;
            AluSra:  w_alu = $signed(w_alu_b) >>> w_shamt;
            AluLui:  w_alu = {bus.signExtImm_EX[15:0], 16'd0};
            default: w_alu = 32'd0;
        endcase
    end

`ifdef MULDIV_EN
    logic w_md_busy;

    ex_muldiv u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_op),
        .i_op     (bus.AluOp_EX),
        .i_a      (w_fwd_a),
        .i_b      (w_alu_b),
        .i_flush  (bus.flush_EX),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    assign w_stall = w_md_busy & ~rst;
`else
    assign w_md_done   = 1'b0;
    assign w_md_result = 32'd0;
    assign w_stall     = 1'b0;
`endif

    assign w_result = w_md_op ? (w_md_done ? w_md_result : 32'd0) : w_alu;
    assign w_bubble = bus.flush_EX | w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= 32'd0;
            r_alu <= 32'd0;
            r_sd  <= 32'd0;
            r_dst <= 5'd0;
            r_rw  <= 1'b0;
            r_mr  <= 1'b0;
            r_m2r <= 1'b0;
            r_mw  <= 1'b0;
        end else if (w_bubble) begin
            r_pc  <= 32'd0;
            r_alu <= 32'd0;
            r_sd  <= 32'd0;
            r_dst <= 5'd0;
            r_rw  <= 1'b0;
            r_mr  <= 1'b0;
            r_m2r <= 1'b0;
            r_mw  <= 1'b0;
        end else begin
            r_pc  <= bus.PC_EX;
            r_alu <= w_result;
            r_sd  <= w_fwd_b;
            r_dst <= bus.RegDst_EX ? bus.reg_rd_EX : bus.reg_rt_EX;
            r_rw  <= bus.reg_write_EX;
            r_mr  <= bus.Memread_EX;
            r_m2r <= bus.MemtoReg_EX;
            r_mw  <= bus.MemWrite_EX;
        end
    end

    assign bus.PC_MEM         = r_pc;
    assign bus.ALU_result_MEM = r_alu;
    assign bus.store_data_MEM = r_sd;
    assign bus.reg_dst_MEM    = r_dst;
    assign bus.reg_write_MEM  = r_rw;
    assign bus.Memread_MEM    = r_mr;
    assign bus.MemtoReg_MEM   = r_m2r;
    assign bus.MemWrite_MEM   = r_mw;
    assign bus.stall_EX       = w_stall;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a behavioural model pushes expected stall/EX-MEM values,
// independent monitors pop and compare. Follows MULDIV_EN the same way as the design.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

`ifdef MULDIV_EN
    localparam bit MdEn = 1'b1;
`else
    localparam bit MdEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  dst;
        logic        rw;
        logic        mr;
        logic        m2r;
        logic        mw;
    } out_t;

    typedef struct {
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic        regdst, rw, mr, m2r, mw, alusrc;
        logic [3:0]  op;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_mem_stage_if bus ();

    ex_mem_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   errors = 0;
    int   checks = 0;
    out_t exp_q[$];
    logic stall_q[$];

    // Model state: what EX/MEM should hold now, and progress through a MUL/DIVU.
    out_t        m_out = '0;
    int          m_cnt = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic        m_stall = 1'b0;

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf,
                                            input out_t mem, input logic wbw,
                                            input logic [4:0] wbr, input logic [31:0] wbd);
        if (r == 0) return rf;
        if (mem.rw && mem.dst == r) return mem.alu;
        if (wbw && wbr == r) return wbd;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        logic [4:0] sh;
        sh = imm[10:6];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << sh;
            4'd9:  return b >> sh;
            4'd10: return 32'($signed(b) >>> sh);
            4'd11: return {imm[15:0], 16'h0000};
            4'd12: return a * b;
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] rd1,
                                  input logic [31:0] rd2, input logic [31:0] imm,
                                  input logic alusrc);
        instr_t i;
        i.pc = $urandom; i.rd1 = rd1; i.rd2 = rd2; i.imm = imm;
        i.rs = rs; i.rt = rt; i.rd = rd; i.regdst = 1'b1; i.rw = 1'b1;
        i.mr = 1'b0; i.m2r = 1'b0; i.mw = 1'b0; i.alusrc = alusrc; i.op = op;
        return i;
    endfunction

    // Drive one cycle of ID/EX inputs, predict stall and the next EX/MEM contents.
    task automatic issue(input instr_t ins, input logic fl, input logic wbw,
                         input logic [4:0] wbr, input logic [31:0] wbd);
        logic [31:0] a, rtv, b;
        out_t nxt, full;
        logic st, is_md;
        bus.PC_EX = ins.pc; bus.regData1_EX = ins.rd1; bus.regData2_EX = ins.rd2;
        bus.signExtImm_EX = ins.imm; bus.reg_rs_EX = ins.rs; bus.reg_rt_EX = ins.rt;
        bus.reg_rd_EX = ins.rd; bus.RegDst_EX = ins.regdst; bus.reg_write_EX = ins.rw;
        bus.Memread_EX = ins.mr; bus.MemtoReg_EX = ins.m2r; bus.MemWrite_EX = ins.mw;
        bus.AluSrc_EX = ins.alusrc; bus.AluOp_EX = alu_op_e'(ins.op);
        bus.flush_EX = fl; bus.wb_reg_write = wbw; bus.wb_reg = wbr; bus.wb_data = wbd;

        a     = ref_fwd(ins.rs, ins.rd1, m_out, wbw, wbr, wbd);
        rtv   = ref_fwd(ins.rt, ins.rd2, m_out, wbw, wbr, wbd);
        b     = ins.alusrc ? ins.imm : rtv;
        is_md = (ins.op == 4'd12) || (ins.op == 4'd13);
        full.pc = ins.pc; full.alu = ref_alu(ins.op, a, b, ins.imm); full.sd = rtv;
        full.dst = ins.regdst ? ins.rd : ins.rt; full.rw = ins.rw; full.mr = ins.mr;
        full.m2r = ins.m2r; full.mw = ins.mw;
        nxt = '0;
        st  = 1'b0;
        if (fl) begin
            m_cnt = 0;
        end else if (is_md && MdEn) begin
            if (m_cnt == 0) begin
                m_a = a;
                m_b = b;
            end
            if (m_cnt < 33) begin
                st = 1'b1;
                m_cnt++;
            end else begin
                full.alu = ref_alu(ins.op, m_a, m_b, ins.imm);
                nxt = full;
                m_cnt = 0;
            end
        end else begin
            if (is_md) full.alu = 32'd0;
            nxt = full;
        end
        m_stall = st;
        stall_q.push_back(st);
        exp_q.push_back(nxt);
        m_out = nxt;
        @(posedge clk);
        #2;
    endtask

    // Issue and hold an instruction until the model says it leaves EX.
    task automatic run(input instr_t ins, input logic fl, input logic wbw, input logic [4:0] wbr,
                       input logic [31:0] wbd, input logic rnd_flush);
        int n;
        n = 0;
        issue(ins, fl, wbw, wbr, wbd);
        while (m_stall && n < 40) begin
            issue(ins, rnd_flush && ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom);
            n++;
        end
        if (m_stall) begin
            checks++;
            errors++;
            $display("FAIL stall_bound: still stalled after %0d cycles, required release", n);
        end
    endtask

    task automatic check_zero(input string name);
        out_t got;
        got = {bus.PC_MEM, bus.ALU_result_MEM, bus.store_data_MEM, bus.reg_dst_MEM,
               bus.reg_write_MEM, bus.Memread_MEM, bus.MemtoReg_MEM, bus.MemWrite_MEM};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: got %h required 0", name, got);
        end
        checks++;
        if (bus.stall_EX !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: got %b required 0", name, bus.stall_EX);
        end
    endtask

    initial begin : mon_stall
        logic s;
        forever begin
            @(negedge clk);
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                checks++;
                if (bus.stall_EX !== s) begin
                    errors++;
                    $display("FAIL stall_EX @%0t: got %b required %b", $time, bus.stall_EX, s);
                end
            end
        end
    end

    initial begin : mon_out
        out_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {bus.PC_MEM, bus.ALU_result_MEM, bus.store_data_MEM, bus.reg_dst_MEM,
                       bus.reg_write_MEM, bus.Memread_MEM, bus.MemtoReg_MEM, bus.MemWrite_MEM};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL ex_mem @%0t: got pc=%h alu=%h sd=%h dst=%0d ctl=%b%b%b%b required pc=%h alu=%h sd=%h dst=%0d ctl=%b%b%b%b",
                             $time, got.pc, got.alu, got.sd, got.dst, got.rw, got.mr, got.m2r,
                             got.mw, e.pc, e.alu, e.sd, e.dst, e.rw, e.mr, e.m2r, e.mw);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        instr_t ins, mul;
        logic [3:0] op;
        issue_init();
        #1 rst = 1'b1;
        #1 check_zero("reset_async");
        @(posedge clk);
        #2 rst = 1'b0;
        check_zero("reset_release");

        // MEM forward then WB forward of $1.
        run(mk(4'd0, 5'd8, 5'd9, 5'd1, 32'd3, 32'd4, 32'd0, 1'b0), 1'b0, 1'b0, 5'd0, 0, 1'b0);
        ins = mk(4'd0, 5'd1, 5'd1, 5'd2, 32'd5, 32'd5, 32'd0, 1'b0);
        run(ins, 1'b0, 1'b0, 5'd0, 0, 1'b0);
        run(ins, 1'b0, 1'b1, 5'd1, 32'd7, 1'b0);

        // MEM beats WB on $3; $0 is never forwarded.
        run(mk(4'd0, 5'd8, 5'd9, 5'd3, 32'd4, 32'd5, 32'd0, 1'b0), 1'b0, 1'b0, 5'd0, 0, 1'b0);
        run(mk(4'd0, 5'd3, 5'd3, 5'd4, 32'd1, 32'd1, 32'd0, 1'b0), 1'b0, 1'b1, 5'd3, 32'd4,
            1'b0);
        run(mk(4'd0, 5'd8, 5'd9, 5'd0, 32'd6, 32'd6, 32'd0, 1'b0), 1'b0, 1'b0, 5'd0, 0, 1'b0);
        run(mk(4'd0, 5'd0, 5'd0, 5'd5, 32'd11, 32'd22, 32'd0, 1'b0), 1'b0, 1'b1, 5'd0, 32'd99,
            1'b0);

        mul = mk(4'd12, 5'd10, 5'd11, 5'd6, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0);
        run(mul, 1'b0, 1'b0, 5'd0, 0, 1'b0);
        run(mk(4'd13, 5'd10, 5'd11, 5'd7, 32'd100, 32'd7, 32'd0, 1'b0), 1'b0, 1'b0, 5'd0, 0, 1'b0);
        run(mk(4'd13, 5'd10, 5'd11, 5'd7, 32'd5, 32'd0, 32'd0, 1'b0), 1'b0, 1'b0, 5'd0, 0, 1'b0);
        run(mk(4'd6, 5'd10, 5'd11, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0), 1'b0, 1'b0, 5'd0, 0,
            1'b0);
        run(mk(4'd7, 5'd10, 5'd11, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0), 1'b0, 1'b0, 5'd0, 0,
            1'b0);
        run(mk(4'd10, 5'd10, 5'd11, 5'd7, 32'd0, 32'h8000_0010, 32'h0000_0100, 1'b0), 1'b0, 1'b0,
            5'd0, 0, 1'b0);
        run(mk(4'd11, 5'd10, 5'd11, 5'd7, 32'd0, 32'd0, 32'h0000_ABCD, 1'b1), 1'b0, 1'b0, 5'd0, 0,
            1'b0);

        // Flush while the MUL counter is at 10, then a full restart.
        for (int k = 0; k < 11; k++) issue(mul, 1'b0, 1'b0, 5'd0, 0);
        issue(mul, 1'b1, 1'b0, 5'd0, 0);
        run(mul, 1'b0, 1'b0, 5'd0, 0, 1'b0);

        // Asynchronous reset with live outputs, then mid-BUSY.
        run(mk(4'd3, 5'd10, 5'd11, 5'd7, 32'h1234_0000, 32'h0000_5678, 32'd0, 1'b0), 1'b0, 1'b0,
            5'd0, 0, 1'b0);
        rst = 1'b1;
        #1 check_zero("reset_live");
        #1 rst = 1'b0;
        m_out = '0;
        m_cnt = 0;
        for (int k = 0; k < 5; k++) issue(mul, 1'b0, 1'b0, 5'd0, 0);
        rst = 1'b1;
        #1 check_zero("reset_busy");
        #1 rst = 1'b0;
        m_out = '0;
        m_cnt = 0;
        run(mul, 1'b0, 1'b0, 5'd0, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            if ((op == 4'd12 || op == 4'd13) && $urandom_range(0, 3) != 0)
                op = 4'($urandom_range(0, 11));
            ins = mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), $urandom, $urandom,
                     ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2047)),
                     1'($urandom_range(0, 1)));
            ins.regdst = 1'($urandom_range(0, 1));
            ins.rw = 1'($urandom_range(0, 1));
            ins.mr = 1'($urandom_range(0, 1));
            ins.m2r = 1'($urandom_range(0, 1));
            ins.mw = 1'($urandom_range(0, 1));
            if (op == 4'd13 && $urandom_range(0, 3) == 0) ins.rd2 = 0;
            run(ins, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), $urandom, 1'b1);
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0 || stall_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d items left, required 0", exp_q.size(), stall_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic issue_init();
        bus.PC_EX = 0; bus.regData1_EX = 0; bus.regData2_EX = 0; bus.signExtImm_EX = 0;
        bus.reg_rs_EX = 0; bus.reg_rt_EX = 0; bus.reg_rd_EX = 0; bus.RegDst_EX = 0;
        bus.reg_write_EX = 0; bus.Memread_EX = 0; bus.MemtoReg_EX = 0; bus.MemWrite_EX = 0;
        bus.AluSrc_EX = 0; bus.AluOp_EX = AluAdd; bus.flush_EX = 0; bus.wb_reg_write = 0;
        bus.wb_reg = 0; bus.wb_data = 0;
    endtask

endmodule
